// File: rtl/buf_axis_reader.sv
// FIFO drain to AXI4-Stream master: one registered read-strobe pulse per word.
// Optional tlast generation under `define BUF_AXIS_READER_TLAST_EN.
module buf_axis_reader #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned CNTWIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              buf_isempty,
    input  logic [DWIDTH-1:0] buf_rdata,
    output logic              buf_re,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              buf_re_q, buf_re_d;
    logic [DWIDTH-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;

    if (CNTWIDTH < 32 && (64'd1 << CNTWIDTH) < 64'(BURST_LEN)) begin : g_cfg_check
        $error("CNTWIDTH too small for BURST_LEN");
    end

`ifdef BUF_AXIS_READER_TLAST_EN
    localparam logic [CNTWIDTH-1:0] LAST_BEAT = CNTWIDTH'(BURST_LEN - 1);

    logic                tlast_q, tlast_d;
    logic [CNTWIDTH-1:0] beat_cnt_q, beat_cnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        buf_re_d = 1'b0;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
`ifdef BUF_AXIS_READER_TLAST_EN
        tlast_d    = tlast_q;
        beat_cnt_d = beat_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // !buf_re_q keeps the strobe low between pulses so the FIFO
                // pointer has settled before the head word is sampled again.
                if (enable && !buf_isempty && !buf_re_q) begin
                    tdata_d  = buf_rdata;
                    tvalid_d = 1'b1;
                    buf_re_d = 1'b1;
                    state_d  = SEND;
`ifdef BUF_AXIS_READER_TLAST_EN
                    tlast_d  = (beat_cnt_q == LAST_BEAT);
`endif
                end
            end
            SEND: begin
                if (tvalid_q && m_axis_tready) begin
                    tvalid_d = 1'b0;
                    state_d  = IDLE;
`ifdef BUF_AXIS_READER_TLAST_EN
                    tlast_d    = 1'b0;
                    beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0
                                                           : beat_cnt_q + CNTWIDTH'(1);
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            buf_re_q <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_re_q <= buf_re_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

`ifdef BUF_AXIS_READER_TLAST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlast_q    <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            tlast_q    <= tlast_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign m_axis_tlast = tlast_q;
`else
    assign m_axis_tlast = 1'b0;
`endif

    assign buf_re        = buf_re_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q == SEND);

endmodule
